// File: rtl/riscv_ctrl.sv
// Multi-cycle RV32 control unit: sequences fetch, execute, memory and writeback,
// and handles traps, mret and wfi around a datapath that decodes the instruction.
module riscv_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [31:0] mem_load_data,
    input  logic        dp_jump,
    input  logic [31:0] dp_jump_target,
    input  logic        dp_is_mem_op,
    input  logic        dp_is_store,
    input  logic [3:0]  dp_exc,
    input  logic        dp_mret,
    input  logic        irq,
    output logic        irf_we,
    output logic        csr_we,
    output logic [31:0] mepc,
    output logic [31:0] mcause,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        WB    = 3'd3,
        TRAP  = 3'd4,
        WAIT  = 3'd5
    } state_t;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_BREAK   = 32'd3;
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;
    localparam logic [31:0] CAUSE_IRQ     = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MISALIGN = 32'd0;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

    state_t      state;
    logic [31:0] trap_cause;
    logic        take_trap;
    logic [31:0] sel_cause;
    logic        wb_irf_we;
    logic        wb_csr_we;

    assign imem_addr = pc;
    assign dbg_state = state;

    // Trap priority in EXEC; misaligned jump target is the lowest-priority trap.
    always_comb begin
        take_trap = 1'b1;
        sel_cause = CAUSE_MISALIGN;
        if (dp_exc[3])
            sel_cause = CAUSE_ILLEGAL;
        else if (dp_exc[2])
            sel_cause = CAUSE_BREAK;
        else if (dp_exc[1])
            sel_cause = CAUSE_ECALL;
        else if (irq)
            sel_cause = CAUSE_IRQ;
        else if (dp_jump && (dp_jump_target[1:0] != 2'b00))
            sel_cause = CAUSE_MISALIGN;
        else
            take_trap = 1'b0;
    end

    // Stores and branches never write rd; SYSTEM with nonzero funct3 is a CSR op.
    assign wb_irf_we = !(dp_is_store || (instr[6:2] == 5'b11000));
    assign wb_csr_we = (instr[6:2] == 5'b11100) && (instr[14:12] != 3'b000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FETCH;
            pc            <= RESET_VECTOR;
            instr         <= NOP_INSTR;
            mem_load_data <= 32'h0;
            mepc          <= 32'h0;
            mcause        <= 32'h0;
            trap_cause    <= 32'h0;
            imem_req      <= 1'b0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            irf_we        <= 1'b0;
            csr_we        <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_req && imem_ack) begin
                        instr    <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= EXEC;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                EXEC: begin
                    if (take_trap) begin
                        trap_cause <= sel_cause;
                        state      <= TRAP;
                    end else if (dp_mret) begin
                        pc       <= mepc;
                        imem_req <= 1'b1;
                        state    <= FETCH;
                    end else if (dp_exc[0]) begin
                        state <= WAIT;
                    end else if (dp_is_mem_op) begin
                        dmem_req <= 1'b1;
                        dmem_we  <= dp_is_store;
                        state    <= MEM;
                    end else begin
                        irf_we <= wb_irf_we;
                        csr_we <= wb_csr_we;
                        state  <= WB;
                    end
                end
                MEM: begin
                    if (dmem_ack) begin
                        if (!dmem_we)
                            mem_load_data <= dmem_rdata;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        irf_we   <= wb_irf_we;
                        csr_we   <= wb_csr_we;
                        state    <= WB;
                    end
                end
                WB: begin
                    irf_we   <= 1'b0;
                    csr_we   <= 1'b0;
                    pc       <= dp_jump ? dp_jump_target : pc + 32'd4;
                    imem_req <= 1'b1;
                    state    <= FETCH;
                end
                TRAP: begin
                    mepc     <= pc;
                    mcause   <= trap_cause;
                    pc       <= TRAP_VECTOR;
                    imem_req <= 1'b1;
                    state    <= FETCH;
                end
                WAIT: begin
                    // The wake-up interrupt is taken at once, returning past the wfi.
                    if (irq) begin
                        mepc     <= pc + 32'd4;
                        mcause   <= CAUSE_IRQ;
                        pc       <= TRAP_VECTOR;
                        imem_req <= 1'b1;
                        state    <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
